// File: rtl/lsu_unit_if.sv
`default_nettype none
// =====================================================================
// lsu_unit_if : request/response and data-memory bundle of the LSU
// Revision    : 1.0
// =====================================================================
interface lsu_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 7
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_fun3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [NB-1:0]     mem_wmask;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_fun3, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    output mem_addr, mem_re, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_fun3, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    input  mem_addr, mem_re, mem_we, mem_wmask, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// =====================================================================
// lsu_unit : load/store unit with lane steering, extension and
//            two-beat handling of word-boundary-crossing accesses
// Revision : 1.0
// =====================================================================
module lsu_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 7,
  parameter int MEM_LAT          = 1,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_unit_if.slave  bus,
  output logic       busy
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;

  logic                w_accept;
  logic [3:0]          w_dec_size;
  logic [OFF_W-1:0]    w_dec_off;
  logic                w_dec_legal, w_dec_cross, w_dec_err;

  logic                r_we, r_uns, r_err, r_cross, r_got;
  logic [3:0]          r_size;
  logic [OFF_W-1:0]    r_off;
  logic [ADDR_W-1:0]   r_word;
  logic [XLEN-1:0]     r_wdata, r_lo, r_hi;
  logic [4:0]          r_rd;
  logic [MEM_LAT-1:0]  r_pipe;

  logic                w_issue, w_ret, w_sign;
  logic [2*XLEN-1:0]   w_pair, w_lane_data;
  logic [2*NB-1:0]     w_ones, w_lane_mask;
  logic [XLEN-1:0]     w_load;

  logic                w_re, w_we, w_rv, w_rerr;
  logic [ADDR_W-1:0]   w_addr;
  logic [NB-1:0]       w_mask;
  logic [XLEN-1:0]     w_wdata, w_rdata;
  logic                unused_bits;

  assign bus.req_ready = (r_state == IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign busy          = (r_state != IDLE);

  // Size/legality decode straight off the request bus, registered on accept
  always_comb begin
    w_dec_size = 4'd1 << bus.req_fun3[1:0];
    w_dec_off  = bus.req_addr[OFF_W-1:0];
    case (bus.req_fun3)
      3'b000, 3'b001, 3'b010: w_dec_legal = 1'b1;
      3'b100, 3'b101:         w_dec_legal = !bus.req_we;
      3'b011:                 w_dec_legal = (XLEN == 64);
      3'b110:                 w_dec_legal = (XLEN == 64) && !bus.req_we;
      default:                w_dec_legal = 1'b0;
    endcase
    w_dec_cross = (5'(w_dec_off) + 5'(w_dec_size)) > 5'(NB);
    w_dec_err   = !w_dec_legal || (w_dec_cross && !ALLOW_MISALIGNED);
  end

  assign w_ret = r_pipe[MEM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_cross <= 1'b0;
      r_got   <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_pipe  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_uns   <= bus.req_fun3[2];
        r_err   <= w_dec_err;
        r_cross <= w_dec_cross;
        r_got   <= 1'b0;
        r_size  <= w_dec_size;
        r_off   <= w_dec_off;
        r_word  <= bus.req_addr[OFF_W +: ADDR_W];
        r_wdata <= bus.req_wdata;
        r_rd    <= bus.req_rd;
      end
      r_pipe[0] <= w_issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      // First returning beat is always the lower word
      if (w_ret) begin
        if (r_got) begin
          r_hi <= bus.mem_rdata;
        end else begin
          r_lo  <= bus.mem_rdata;
          r_got <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pair = {r_hi, r_lo} >> {r_off, 3'b000};
    case (r_size)
      4'd1:    w_sign = w_pair[7];
      4'd2:    w_sign = w_pair[15];
      4'd4:    w_sign = w_pair[31];
      default: w_sign = w_pair[XLEN-1];
    endcase
    w_sign = w_sign & ~r_uns;
    w_load = '0;
    for (int b = 0; b < NB; b++) begin
      w_load[8*b +: 8] = (b < int'(r_size)) ? w_pair[8*b +: 8] : {8{w_sign}};
    end
  end

  always_comb begin
    w_lane_data = {{XLEN{1'b0}}, r_wdata} << {r_off, 3'b000};
    w_ones      = '0;
    for (int b = 0; b < 2*NB; b++) begin
      w_ones[b] = (b < int'(r_size));
    end
    w_lane_mask = w_ones << r_off;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_re        = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_mask      = '0;
    w_wdata     = '0;
    w_rv        = 1'b0;
    w_rerr      = 1'b0;
    w_rdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_dec_err ? RESP : BEAT0;
      end
      BEAT0: begin
        w_addr = r_word;
        if (r_we) begin
          w_we        = 1'b1;
          w_mask      = w_lane_mask[NB-1:0];
          w_wdata     = w_lane_data[XLEN-1:0];
          w_rv        = !r_cross;
          w_state_nxt = r_cross ? BEAT1 : IDLE;
        end else begin
          w_re        = 1'b1;
          w_state_nxt = r_cross ? BEAT1 : WAIT;
        end
      end
      BEAT1: begin
        w_addr = r_word + ADDR_W'(1);
        if (r_we) begin
          w_we        = 1'b1;
          w_mask      = w_lane_mask[2*NB-1:NB];
          w_wdata     = w_lane_data[2*XLEN-1:XLEN];
          w_rv        = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_re        = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_ret && (r_got || !r_cross)) w_state_nxt = RESP;
      end
      RESP: begin
        w_rv        = 1'b1;
        w_rerr      = r_err;
        w_rdata     = r_err ? '0 : w_load;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_issue        = w_re;
  assign bus.mem_re     = w_re;
  assign bus.mem_we     = w_we;
  assign bus.mem_addr   = w_addr;
  assign bus.mem_wmask  = w_mask;
  assign bus.mem_wdata  = w_wdata;
  assign bus.resp_valid = w_rv;
  assign bus.resp_err   = w_rerr;
  assign bus.resp_rdata = w_rdata;
  assign bus.resp_rd    = w_rv ? r_rd : 5'd0;

  assign unused_bits = ^{bus.req_addr, w_pair[2*XLEN-1:XLEN]};
endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// =====================================================================
// tb_lsu_unit : directed scoreboard bench over four LSU configurations
// Revision    : 1.0
// =====================================================================
module tb_lsu_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request fields; per-instance valid
  logic [3:0]  vld;
  logic        we;
  logic [2:0]  f3;
  logic [63:0] addr, wdata;
  logic [4:0]  rd;

  logic [3:0]  o_ready, o_rv, o_err, o_re, o_we, o_busy;
  logic [63:0] o_rdata [4];
  logic [63:0] o_wdata [4];
  logic [7:0]  o_mask  [4];
  logic [6:0]  o_addr  [4];
  logic [4:0]  o_rd    [4];
  logic [63:0] rdat    [4];

  // A: 32b lat1 misaligned-ok, B: 32b lat3, C: 32b misaligned-error, D: 64b
  lsu_unit_if #(.XLEN(32), .ADDR_W(7)) if_a ();
  lsu_unit_if #(.XLEN(32), .ADDR_W(7)) if_b ();
  lsu_unit_if #(.XLEN(32), .ADDR_W(7)) if_c ();
  lsu_unit_if #(.XLEN(64), .ADDR_W(7)) if_d ();

  lsu_unit #(.XLEN(32), .ADDR_W(7), .MEM_LAT(1), .ALLOW_MISALIGNED(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a), .busy(o_busy[0]));
  lsu_unit #(.XLEN(32), .ADDR_W(7), .MEM_LAT(3), .ALLOW_MISALIGNED(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b), .busy(o_busy[1]));
  lsu_unit #(.XLEN(32), .ADDR_W(7), .MEM_LAT(1), .ALLOW_MISALIGNED(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c), .busy(o_busy[2]));
  lsu_unit #(.XLEN(64), .ADDR_W(7), .MEM_LAT(1), .ALLOW_MISALIGNED(1'b1))
    dut_d (.clk(clk), .rst(rst), .bus(if_d), .busy(o_busy[3]));

  assign if_a.req_valid = vld[0]; assign if_a.req_we = we; assign if_a.req_fun3 = f3;
  assign if_a.req_addr = addr[31:0]; assign if_a.req_wdata = wdata[31:0]; assign if_a.req_rd = rd;
  assign if_a.mem_rdata = rdat[0][31:0];
  assign o_ready[0] = if_a.req_ready; assign o_rv[0] = if_a.resp_valid; assign o_err[0] = if_a.resp_err;
  assign o_re[0] = if_a.mem_re; assign o_we[0] = if_a.mem_we; assign o_rd[0] = if_a.resp_rd;
  assign o_rdata[0] = {32'h0, if_a.resp_rdata}; assign o_wdata[0] = {32'h0, if_a.mem_wdata};
  assign o_mask[0] = {4'h0, if_a.mem_wmask}; assign o_addr[0] = if_a.mem_addr;

  assign if_b.req_valid = vld[1]; assign if_b.req_we = we; assign if_b.req_fun3 = f3;
  assign if_b.req_addr = addr[31:0]; assign if_b.req_wdata = wdata[31:0]; assign if_b.req_rd = rd;
  assign if_b.mem_rdata = rdat[1][31:0];
  assign o_ready[1] = if_b.req_ready; assign o_rv[1] = if_b.resp_valid; assign o_err[1] = if_b.resp_err;
  assign o_re[1] = if_b.mem_re; assign o_we[1] = if_b.mem_we; assign o_rd[1] = if_b.resp_rd;
  assign o_rdata[1] = {32'h0, if_b.resp_rdata}; assign o_wdata[1] = {32'h0, if_b.mem_wdata};
  assign o_mask[1] = {4'h0, if_b.mem_wmask}; assign o_addr[1] = if_b.mem_addr;

  assign if_c.req_valid = vld[2]; assign if_c.req_we = we; assign if_c.req_fun3 = f3;
  assign if_c.req_addr = addr[31:0]; assign if_c.req_wdata = wdata[31:0]; assign if_c.req_rd = rd;
  assign if_c.mem_rdata = rdat[2][31:0];
  assign o_ready[2] = if_c.req_ready; assign o_rv[2] = if_c.resp_valid; assign o_err[2] = if_c.resp_err;
  assign o_re[2] = if_c.mem_re; assign o_we[2] = if_c.mem_we; assign o_rd[2] = if_c.resp_rd;
  assign o_rdata[2] = {32'h0, if_c.resp_rdata}; assign o_wdata[2] = {32'h0, if_c.mem_wdata};
  assign o_mask[2] = {4'h0, if_c.mem_wmask}; assign o_addr[2] = if_c.mem_addr;

  assign if_d.req_valid = vld[3]; assign if_d.req_we = we; assign if_d.req_fun3 = f3;
  assign if_d.req_addr = addr; assign if_d.req_wdata = wdata; assign if_d.req_rd = rd;
  assign if_d.mem_rdata = rdat[3];
  assign o_ready[3] = if_d.req_ready; assign o_rv[3] = if_d.resp_valid; assign o_err[3] = if_d.resp_err;
  assign o_re[3] = if_d.mem_re; assign o_we[3] = if_d.mem_we; assign o_rd[3] = if_d.resp_rd;
  assign o_rdata[3] = if_d.resp_rdata; assign o_wdata[3] = if_d.mem_wdata;
  assign o_mask[3] = if_d.mem_wmask; assign o_addr[3] = if_d.mem_addr;

  // Memory model: byte-masked writes, fixed-latency read pipe per instance
  logic [63:0] mem [4][128];
  logic [63:0] rp  [4][4];
  logic        pl_en;
  int          pl_i;
  logic [6:0]  pl_a;
  logic [63:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) mem[pl_i][pl_a] <= pl_d;
    for (int i = 0; i < 4; i++) begin
      if (o_we[i]) begin
        for (int b = 0; b < 8; b++)
          if (o_mask[i][b]) mem[i][o_addr[i]][8*b +: 8] <= o_wdata[i][8*b +: 8];
      end
      rp[i][0] <= o_re[i] ? mem[i][o_addr[i]] : 64'h0;
      for (int k = 1; k < 4; k++) rp[i][k] <= rp[i][k-1];
    end
  end
  assign rdat[0] = rp[0][0];
  assign rdat[1] = rp[1][2];
  assign rdat[2] = rp[2][0];
  assign rdat[3] = rp[3][0];

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] cyc;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;
  exp_t sbq [$];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (o_rv[i] === 1'b1) begin
        chk("resp_pending", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("resp_sel",   64'(i),          64'(e.sel));
          chk("resp_cycle", 64'(cyc),        64'(e.cyc));
          chk("resp_rdata", o_rdata[i],      e.rdata);
          chk("resp_rd",    64'(o_rd[i]),    64'(e.rd));
          chk("resp_err",   64'(o_err[i]),   64'(e.err));
        end
      end
    end
  end

  task automatic load_mem(input int i, input logic [6:0] a, input logic [63:0] d);
    pl_i = i; pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1
  task automatic issue(input int s, input logic w, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] d, input logic [4:0] r, input int k,
                       input logic [63:0] er, input logic ee, input bit push);
    exp_t e;
    we = w; f3 = f; addr = a; wdata = d; rd = r; vld[s] = 1'b1;
    chk("req_ready", 64'(o_ready[s]), 64'd1);
    @(posedge clk); #1;
    if (push) begin
      e.sel = 2'(s); e.cyc = 32'(cyc + k - 1); e.rdata = er; e.rd = r; e.err = ee;
      sbq.push_back(e);
    end
    @(negedge clk);
    vld[s] = 1'b0;
  endtask

  task automatic beat(input int s, input string tag, input logic bre, input logic bwe,
                      input logic [6:0] a, input logic [7:0] m, input logic [63:0] d);
    chk({tag, "_re"}, 64'(o_re[s]), 64'(bre));
    chk({tag, "_we"}, 64'(o_we[s]), 64'(bwe));
    if (bre || bwe) chk({tag, "_addr"}, 64'(o_addr[s]), 64'(a));
    if (bwe) begin
      chk({tag, "_mask"},  64'(o_mask[s]), 64'(m));
      chk({tag, "_wdata"}, o_wdata[s], d);
    end
    @(negedge clk);
  endtask

  task automatic settle(input int s);
    int n;
    n = 0;
    while ((sbq.size() != 0 || o_busy[s] !== 1'b0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("settle", 64'(n < 30), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vld = 4'h0; we = 1'b0; f3 = 3'd0; addr = '0; wdata = '0; rd = '0;
    pl_en = 1'b0; pl_i = 0; pl_a = '0; pl_d = '0;
    @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'h0);
    chk("rst_busy",  64'(o_busy),  64'h0);
    chk("rst_resp",  64'(o_rv),    64'h0);
    chk("rst_mem",   64'(o_re | o_we), 64'h0);
    for (int i = 0; i < 3; i++) begin
      load_mem(i, 7'd1, 64'hDEADBEEF);
      load_mem(i, 7'd2, 64'h11223344);
    end
    load_mem(0, 7'd127, 64'h80000000);
    load_mem(0, 7'd0,   64'h00000001);
    load_mem(1, 7'd3,   64'h0);
    load_mem(3, 7'd1,   64'h0);
    load_mem(3, 7'd2,   64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(o_ready), 64'hF);

    // byte/half/word loads on A
    issue(0, 1'b0, 3'b000, 64'h07, 64'h0, 5'd3, 3, 64'hFFFFFFDE, 1'b0, 1'b1);
    beat(0, "lb_b0", 1'b1, 1'b0, 7'd1, 8'h0, 64'h0);
    beat(0, "lb_b1", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(0);
    issue(0, 1'b0, 3'b100, 64'h07, 64'h0, 5'd4, 3, 64'h000000DE, 1'b0, 1'b1); settle(0);
    issue(0, 1'b0, 3'b001, 64'h06, 64'h0, 5'd6, 3, 64'hFFFFDEAD, 1'b0, 1'b1); settle(0);
    issue(0, 1'b0, 3'b010, 64'h04, 64'h0, 5'd7, 3, 64'hDEADBEEF, 1'b0, 1'b1); settle(0);

    // crossing loads
    issue(0, 1'b0, 3'b010, 64'h06, 64'h0, 5'd5, 4, 64'h3344DEAD, 1'b0, 1'b1);
    beat(0, "lwx_b0", 1'b1, 1'b0, 7'd1, 8'h0, 64'h0);
    beat(0, "lwx_b1", 1'b1, 1'b0, 7'd2, 8'h0, 64'h0);
    beat(0, "lwx_b2", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(0);
    issue(0, 1'b0, 3'b001, 64'h07, 64'h0, 5'd8, 4, 64'h000044DE, 1'b0, 1'b1); settle(0);
    issue(0, 1'b0, 3'b001, 64'hFFFFFFFF, 64'h0, 5'd9, 4, 64'h00000180, 1'b0, 1'b1);
    beat(0, "wrap_b0", 1'b1, 1'b0, 7'd127, 8'h0, 64'h0);
    beat(0, "wrap_b1", 1'b1, 1'b0, 7'd0,   8'h0, 64'h0);
    settle(0);

    // latency 3
    issue(1, 1'b0, 3'b010, 64'h06, 64'h0, 5'd5, 6, 64'h3344DEAD, 1'b0, 1'b1); settle(1);
    issue(1, 1'b0, 3'b000, 64'h07, 64'h0, 5'd2, 5, 64'hFFFFFFDE, 1'b0, 1'b1); settle(1);

    // stores on B
    issue(1, 1'b1, 3'b001, 64'h06, 64'h0000CAFE, 5'd1, 1, 64'h0, 1'b0, 1'b1);
    beat(1, "sh_b0", 1'b0, 1'b1, 7'd1, 8'h0C, 64'hCAFE0000);
    beat(1, "sh_b1", 1'b0, 1'b0, 7'd0, 8'h00, 64'h0);
    settle(1);
    issue(1, 1'b1, 3'b010, 64'h0B, 64'hAABBCCDD, 5'd10, 2, 64'h0, 1'b0, 1'b1);
    beat(1, "swx_b0", 1'b0, 1'b1, 7'd2, 8'h08, 64'hDD000000);
    beat(1, "swx_b1", 1'b0, 1'b1, 7'd3, 8'h07, 64'h00AABBCC);
    settle(1);
    issue(1, 1'b0, 3'b010, 64'h0B, 64'h0, 5'd11, 6, 64'hAABBCCDD, 1'b0, 1'b1); settle(1);

    // error responses
    issue(2, 1'b0, 3'b010, 64'h06, 64'h0, 5'd12, 1, 64'h0, 1'b1, 1'b1);
    beat(2, "misal_b0", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    beat(2, "misal_b1", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(2);
    issue(2, 1'b1, 3'b010, 64'h06, 64'h12345678, 5'd13, 1, 64'h0, 1'b1, 1'b1);
    beat(2, "smisal_b0", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(2);
    issue(2, 1'b0, 3'b010, 64'h04, 64'h0, 5'd14, 3, 64'hDEADBEEF, 1'b0, 1'b1); settle(2);
    issue(0, 1'b0, 3'b011, 64'h00, 64'h0, 5'd15, 1, 64'h0, 1'b1, 1'b1);
    beat(0, "ld32_b0", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(0);
    issue(0, 1'b1, 3'b100, 64'h04, 64'hFF, 5'd16, 1, 64'h0, 1'b1, 1'b1);
    beat(0, "sbu_b0", 1'b0, 1'b0, 7'd0, 8'h0, 64'h0);
    settle(0);
    issue(3, 1'b0, 3'b111, 64'h08, 64'h0, 5'd17, 1, 64'h0, 1'b1, 1'b1); settle(3);

    // 64-bit datapath
    issue(3, 1'b1, 3'b011, 64'h0C, 64'h0123456789ABCDEF, 5'd18, 2, 64'h0, 1'b0, 1'b1);
    beat(3, "sd_b0", 1'b0, 1'b1, 7'd1, 8'hF0, 64'h89ABCDEF00000000);
    beat(3, "sd_b1", 1'b0, 1'b1, 7'd2, 8'h0F, 64'h0000000001234567);
    settle(3);
    issue(3, 1'b0, 3'b011, 64'h0C, 64'h0, 5'd19, 4, 64'h0123456789ABCDEF, 1'b0, 1'b1); settle(3);
    issue(3, 1'b0, 3'b010, 64'h0C, 64'h0, 5'd20, 3, 64'hFFFFFFFF89ABCDEF, 1'b0, 1'b1); settle(3);
    issue(3, 1'b0, 3'b110, 64'h0C, 64'h0, 5'd21, 3, 64'h0000000089ABCDEF, 1'b0, 1'b1); settle(3);

    // reset during a crossing load: no response may follow
    issue(0, 1'b0, 3'b010, 64'h06, 64'h0, 5'd5, 4, 64'h0, 1'b0, 1'b0);
    beat(0, "abort_b0", 1'b1, 1'b0, 7'd1, 8'h0, 64'h0);
    rst = 1'b1;
    #1;
    chk("abort_re",    64'(o_re[0]),    64'd0);
    chk("abort_resp",  64'(o_rv[0]),    64'd0);
    chk("abort_busy",  64'(o_busy[0]),  64'd0);
    chk("abort_ready", 64'(o_ready[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_ready_after", 64'(o_ready[0]), 64'd1);
    issue(0, 1'b0, 3'b010, 64'h04, 64'h0, 5'd22, 3, 64'hDEADBEEF, 1'b0, 1'b1); settle(0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
`default_nettype wire
